// File: rtl/cpu_core_pkg.sv
// Shared definitions for cpu_core and its program-memory loader.
package cpu_core_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT = 8;
  localparam int unsigned INSTR_WIDTH      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } pm_loader_state_t;

endpackage

// File: rtl/pm_checksum.sv
// 16-bit modular accumulator over loaded instruction words.
// Only built when PM_LOADER_CHECKSUM_EN is defined.
`ifdef PM_LOADER_CHECKSUM_EN
module pm_checksum
  import cpu_core_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   acc_en_i,
  input  logic [INSTR_WIDTH-1:0] data_i,
  output logic [INSTR_WIDTH-1:0] sum_o
);

  logic [INSTR_WIDTH-1:0] sum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (acc_en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/pm_loader.sv
// Program-memory loader: writes a length-prefixed word stream from address 0 and holds
// cpu_core in reset until the image is complete. PM_LOADER_CHECKSUM_EN adds a trailing checksum.
module pm_loader
  import cpu_core_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_data,
  output logic                   pm_we,
  output logic [PC_WIDTH-1:0]    pm_addr,
  output logic [INSTR_WIDTH-1:0] pm_wdata,
  output logic                   core_reset,
  output logic                   busy,
  output logic                   error
);

  localparam int unsigned LEN_WIDTH = PC_WIDTH + 1;

  pm_loader_state_t     state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic                 xfer;
  logic                 oversize;
  logic                 last_word;

  // Outputs decode the state register only, so in_ready never depends on in_valid.
  assign in_ready   = (state_q == LEN) || (state_q == LOAD) || (state_q == CHECK);
  assign busy       = in_ready;
  assign core_reset = (state_q != RUN);
  assign error      = (state_q == ERROR);

  assign xfer      = in_valid && in_ready;
  assign oversize  = 32'(in_data) > (32'd1 << PC_WIDTH);
  assign last_word = (count_q + 1'b1) == len_q;

`ifdef PM_LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0] sum;

  pm_checksum u_checksum (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (state_q == LEN),
    .acc_en_i(xfer && (state_q == LOAD)),
    .data_i  (in_data),
    .sum_o   (sum)
  );

  localparam pm_loader_state_t DONE_STATE = CHECK;
`else
  localparam pm_loader_state_t DONE_STATE = RUN;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      count_q  <= '0;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
    end else begin
      pm_we <= 1'b0;
      unique case (state_q)
        IDLE, RUN, ERROR: begin
          if (load_start) state_q <= LEN;
        end
        LEN: begin
          if (xfer) begin
            count_q <= '0;
            len_q   <= LEN_WIDTH'(in_data);
            if (oversize) begin
              state_q <= ERROR;
            end else if (in_data == '0) begin
              state_q <= DONE_STATE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            pm_we    <= 1'b1;
            // Address comes from the word counter, so a full-capacity image never wraps.
            pm_addr  <= count_q[PC_WIDTH-1:0];
            pm_wdata <= in_data;
            count_q  <= count_q + 1'b1;
            if (last_word) state_q <= DONE_STATE;
          end
        end
`ifdef PM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) state_q <= (in_data == sum) ? RUN : ERROR;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Scoreboard bench for pm_loader (PC_WIDTH=4); honours PM_LOADER_CHECKSUM_EN.
module tb_pm_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        pm_we;
  logic [3:0]  pm_addr;
  logic [15:0] pm_wdata;
  logic        core_reset;
  logic        busy;
  logic        error;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [15:0] img[0:15];

  pm_loader #(.PC_WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .load_start(load_start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .pm_we     (pm_we),
    .pm_addr   (pm_addr),
    .pm_wdata  (pm_wdata),
    .core_reset(core_reset),
    .busy      (busy),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Every write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && pm_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(pm_addr), 32'hffff_ffff);
      end else begin
        exp_w = exp_q.pop_front();
        check("we_addr", 32'(pm_addr), 32'(exp_w[31:16]));
        check("we_data", 32'(pm_wdata), 32'(exp_w[15:0]));
      end
    end
  end

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the word was accepted.
  task automatic send(input logic [15:0] w, input bit gap, input bit poke);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 16) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    if (gap) begin
      load_start = poke;
      @(negedge clock);
      load_start = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (2) @(negedge clock);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_load(input int n, input bit gap, input bit poke);
    logic [15:0] sum = '0;
    pulse_start();
    check("ready_after_start", 32'(in_ready), 32'd1);
    check("busy_len", 32'(busy), 32'd1);
    check("core_reset_len", 32'(core_reset), 32'd1);
    check("error_cleared", 32'(error), 32'd0);
    send(16'(n), gap, 1'b0);
    for (int i = 0; i < n; i++) begin
      sum += img[i];
      exp_q.push_back({16'(i), img[i]});
`ifdef PM_LOADER_CHECKSUM_EN
      send(img[i], gap, poke);
`else
      if (i == n - 1) begin
        check("core_reset_held", 32'(core_reset), 32'd1);
        send(img[i], 1'b0, 1'b0);
      end else begin
        send(img[i], gap, poke);
      end
`endif
    end
`ifdef PM_LOADER_CHECKSUM_EN
    check("core_reset_held", 32'(core_reset), 32'd1);
    send(sum, 1'b0, 1'b0);
`endif
    check("core_reset_released", 32'(core_reset), 32'd0);
    check("error_after_load", 32'(error), 32'd0);
    check("busy_after_load", 32'(busy), 32'd0);
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_pm_we"}, 32'(pm_we), 32'd0);
    check({tag, "_pm_addr"}, 32'(pm_addr), 32'd0);
    check({tag, "_pm_wdata"}, 32'(pm_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", 32'(in_ready), 32'd0);

    // Three-word image.
    img[0] = 16'h1111;
    img[1] = 16'h2222;
    img[2] = 16'h3333;
    run_load(3, 1'b0, 1'b0);

    // in_valid every other cycle, with a load_start poke that must be ignored.
    for (int i = 0; i < 4; i++) img[i] = 16'($urandom);
    run_load(4, 1'b1, 1'b1);

    // Empty image.
    run_load(0, 1'b0, 1'b0);

    // Oversize length leaves the core in reset with error raised.
    pulse_start();
    send(16'd17, 1'b0, 1'b0);
    check("oversize_error", 32'(error), 32'd1);
    check("oversize_core_reset", 32'(core_reset), 32'd1);
    check("oversize_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check("error_sticky", 32'(error), 32'd1);
    check("error_core_reset_sticky", 32'(core_reset), 32'd1);
    drain();

    // Full-capacity image fills addresses 0..15.
    for (int i = 0; i < 16; i++) img[i] = 16'($urandom);
    run_load(16, 1'b0, 1'b0);

`ifdef PM_LOADER_CHECKSUM_EN
    // Wrong checksum: words still written, core stays in reset.
    pulse_start();
    send(16'd2, 1'b0, 1'b0);
    exp_q.push_back({16'd0, 16'h0001});
    exp_q.push_back({16'd1, 16'h0002});
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h0004, 1'b0, 1'b0);
    check("cksum_error", 32'(error), 32'd1);
    check("cksum_core_reset", 32'(core_reset), 32'd1);
    drain();
`endif

    // Reset after the 2nd of 5 words.
    for (int i = 0; i < 5; i++) img[i] = 16'($urandom);
    pulse_start();
    send(16'd5, 1'b0, 1'b0);
    exp_q.push_back({16'd0, img[0]});
    exp_q.push_back({16'd1, img[1]});
    send(img[0], 1'b0, 1'b0);
    send(img[1], 1'b0, 1'b0);
    #2;
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    check("midrst_idle_ready", 32'(in_ready), 32'd0);
    drain();

    // Recovery after reset.
    img[0] = 16'hbeef;
    img[1] = 16'h0f0f;
    img[2] = 16'hffff;
    run_load(3, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
# pm_loader

Program-memory loader for `cpu_core`. It accepts a length-prefixed stream of 16-bit instruction words over a valid/ready handshake and writes them into program memory from address 0 upward. It holds the core in reset while loading and releases it once the image is complete and valid. It sits between the host/debug link and the program-memory write port; `cpu_core` fetches from the read side of the same memory.

## Interface
- `PC_WIDTH`, default 8: program-memory address width; capacity is 2^PC_WIDTH words.
- `clock` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `load_start` input 1: single-cycle pulse; begins a load. Accepted only in IDLE, RUN or ERROR.
- `in_valid` input 1: stream word valid.
- `in_ready` output 1: loader can accept a word.
- `in_data` input 16: stream word.
- `pm_we` output 1: program-memory write enable, one cycle per word.
- `pm_addr` output PC_WIDTH: program-memory write address.
- `pm_wdata` output 16: program-memory write data.
- `core_reset` output 1: drives the `cpu_core` reset.
- `busy` output 1: load in progress.
- `error` output 1: last load failed; sticky until the next `load_start` or `reset`.

## Operation
- A transfer occurs on a cycle where `in_valid && in_ready`. Words are never dropped or duplicated. `in_data` is ignored when no transfer occurs.
- Stream format: the first word is the length N, then N instruction words, then (with `PM_LOADER_CHECKSUM_EN`) one checksum word.
- States:
  - IDLE: `core_reset`=1. `load_start` moves to LEN.
  - LEN: `in_ready`=1. On transfer:
    - N > 2^PC_WIDTH → ERROR.
    - N = 0 → CHECK if checksum is enabled, else RUN.
    - otherwise → LOAD. The word counter and address are cleared to 0.
  - LOAD: `in_ready`=1. Each transfer writes one word to the current address, then the address increments. After the Nth word → CHECK if checksum is enabled, else RUN.
  - CHECK: `in_ready`=1. On transfer, a word equal to the 16-bit modular sum of the N instruction words → RUN; any other word → ERROR.
  - RUN: `core_reset`=0. `load_start` moves to LEN and reasserts `core_reset` on the next cycle.
  - ERROR: `core_reset`=1, `error`=1. `load_start` moves to LEN and clears `error`.
- `busy`=1 in LEN, LOAD and CHECK.
- `in_ready` is decoded from the registered state only. It has no combinational path from `in_valid`.
- `load_start` is ignored in LEN, LOAD and CHECK.
- An address never wraps. N = 2^PC_WIDTH fills addresses 0 through 2^PC_WIDTH-1 exactly. The length is held in a PC_WIDTH+1-bit counter.
- Memory locations beyond N keep their old contents.

## Timing
- Reset values:
  - state = IDLE
  - `core_reset`=1
  - `in_ready`=0, `pm_we`=0
  - `pm_addr`=0, `pm_wdata`=0
  - `busy`=0, `error`=0
- Write latency is 1 cycle. An instruction transfer on edge k drives `pm_we`=1 with the registered address and data during cycle k+1.
- Back-to-back transfers produce `pm_we` on consecutive cycles.
- `core_reset` deasserts on the cycle after the final transfer that enters RUN. This is also the cycle of the last `pm_we`, so the core's first fetch is never earlier than one cycle after the last write.
- `load_start` to `in_ready`=1: 1 cycle.
- Asserting `reset` mid-load returns the block to IDLE immediately with all outputs at their reset values. Any partial image remains in memory.

## Configuration
- `PM_LOADER_CHECKSUM_EN` defined:
  - the CHECK state exists;
  - one trailing checksum word is required;
  - a mismatch → ERROR and the core stays in reset.
- `PM_LOADER_CHECKSUM_EN` undefined:
  - there is no CHECK state or accumulator;
  - RUN is entered directly after the Nth word (or after LEN when N = 0);
  - `error` is raised only for an oversize N.

## Structure
- Shared package `cpu_core_pkg` holds:
  - `PC_WIDTH` default;
  - `INSTR_WIDTH` = 16;
  - enum `pm_loader_state_t` {IDLE, LEN, LOAD, CHECK, RUN, ERROR}.
- Sub-module `pm_checksum` is present only under the macro. It is a 16-bit accumulator with a clear input, an accumulate-enable input and a sum output.

## Test plan
- Load of 3 words (stream 3, 0x1111, 0x2222, 0x3333, and checksum 0x6666 when enabled) → `pm_we` at addresses 0, 1, 2 with matching data; `core_reset` falls one cycle after the last transfer; `error`=0.
- `in_valid` toggled every other cycle during a 4-word load → exactly 4 writes at addresses 0–3, in order, with no gaps in address.
- N = 0 → no `pm_we`; RUN is entered (after checksum word 0x0000 when enabled).
- With PC_WIDTH=4, N = 17 → ERROR, `error`=1, `core_reset` stays 1. A following `load_start` and a valid load clear `error`.
- Checksum enabled, stream 2, 0x0001, 0x0002, 0x0004 → ERROR, core held in reset.
- `reset` asserted after the 2nd of 5 words → IDLE on the same edge; all outputs at reset values; `in_ready`=0.
